instr_loader: RTL and testbench

Write-side counterpart to the instruction ROM: accepts a stream of 9-bit machine-code words from a host (testbench driver or serial deframer) and writes them sequentially into the instruction memory's write port starting at address 0. It holds the core in reset while loading. It verifies a trailing XOR checksum before releasing the core. It sits between the host link and the instruction memory, ahead of the program counter/fetch path.

---
 rtl/instr_loader_if.sv | 22 ++
 rtl/instr_loader.sv | 107 ++++++++++
 tb/tb_instr_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - host word stream and instruction-memory write port bundle
interface instr_loader_if #(
    parameter int D = 12
) ();
    logic [8:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [8:0]   wr_data;

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams host words into instruction memory and gates core reset on checksum
module instr_loader #(
    parameter int D = 12
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    instr_loader_if.slave  bus,
    output logic [D:0]     word_count,
    output logic           core_hold,
    output logic           done,
    output logic           error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t       state_q, state_d;
    logic [D-1:0] ptr_q;
    logic [D:0]   count_q;
    logic [8:0]   acc_q;
    logic         wr_en_q;
    logic [D-1:0] wr_addr_q;
    logic [8:0]   wr_data_q;

    logic ready;
    logic hs;
    logic ptr_last;
    logic session_start;

    assign hs            = bus.in_valid && ready;
    assign ptr_last      = &ptr_q;
    assign session_start = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (hs) begin
                    if (bus.in_last)   state_d = S_CHECK;
                    else if (ptr_last) state_d = S_ERROR;
                end
            end
            S_CHECK: begin
                if (hs) state_d = (bus.in_data == acc_q) ? S_DONE : S_ERROR;
            end
            S_DONE:  if (start) state_d = S_LOAD;
            S_ERROR: if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == S_LOAD) || (state_q == S_CHECK);
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERROR);
        core_hold = (state_q != S_DONE);
    end

    // Write port is registered so a handshake in cycle N appears as a write in N+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            count_q   <= '0;
            acc_q     <= 9'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 9'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (session_start) begin
                ptr_q   <= '0;
                count_q <= '0;
                acc_q   <= 9'b0;
            end
            if (state_q == S_LOAD && hs) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= ptr_q;
                wr_data_q <= bus.in_data;
                ptr_q     <= ptr_q + 1'b1;
                count_q   <= count_q + 1'b1;
                acc_q     <= acc_q ^ bus.in_data;
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign word_count   = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized self-checking bench for instr_loader against a session-level model
module tb_instr_loader;
    localparam int D     = 3;
    localparam int DEPTH = 1 << D;

    typedef logic [8:0] wq_t[$];
    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic [D:0]   word_count;
    logic         core_hold;
    logic         done;
    logic         error;

    instr_loader_if #(.D(D)) bus ();

    instr_loader #(.D(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bus        (bus),
        .word_count (word_count),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    wr_t        exp_q[$];
    logic [8:0] mem_m[DEPTH];
    bit         bb = 0;
    int         n_wr = 0;
    int         last_wr_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Write-port monitor: every write must match the next expected (addr, data).
    always @(negedge clk) begin
        wr_t e;
        if (reset_n && bus.wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, e.addr);
                check("wr_data", bus.wr_data, e.data);
            end
            if (bb && n_wr > 0) check("wr_gap", cyc - last_wr_cyc, 1);
            mem_m[bus.wr_addr] = bus.wr_data;
            last_wr_cyc = cyc;
            n_wr++;
        end
    end

    // Tasks are entered and left just after a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [8:0] data, input bit last, input int stall);
        int t;
        repeat (stall) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 9'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("hs_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 9'($urandom);
        bus.in_last  = 1'($urandom);
    endtask

    task automatic session(input wq_t w, input int last_idx, input bit cs_ok,
                           input int stall_max, input bit bb_mode);
        int         ptr;
        int         cnt;
        logic [8:0] acc;
        logic [8:0] cs;
        bit         to_check;
        ptr = 0; cnt = 0; acc = 9'b0; to_check = 0;
        pulse_start();
        n_wr = 0;
        bb   = bb_mode;
        for (int i = 0; i < w.size(); i++) begin
            exp_q.push_back('{addr: ptr, data: int'(w[i])});
            send_word(w[i], i == last_idx, $urandom_range(0, stall_max));
            acc = acc ^ w[i];
            cnt++;
            if (i == last_idx) begin
                to_check = 1;
                break;
            end
            if (ptr == DEPTH - 1) break;
            ptr++;
        end
        if (to_check) begin
            check("ready_in_check", bus.in_ready, 1);
            cs = cs_ok ? acc : (acc ^ 9'($urandom_range(1, 511)));
            send_word(cs, 1'($urandom), $urandom_range(0, stall_max));
            check("done", done, cs_ok);
            check("error", error, !cs_ok);
            check("core_hold", core_hold, !cs_ok);
        end else begin
            check("ovf_error", error, 1);
            check("ovf_done", done, 0);
            check("ovf_hold", core_hold, 1);
        end
        check("word_count", word_count, cnt);
        check("ready_after", bus.in_ready, 0);
        @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
        bb = 0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_in_ready"}, bus.in_ready, 0);
        check({pfx, "_wr_en"}, bus.wr_en, 0);
        check({pfx, "_wr_addr"}, bus.wr_addr, 0);
        check({pfx, "_wr_data"}, bus.wr_data, 0);
        check({pfx, "_word_count"}, word_count, 0);
        check({pfx, "_core_hold"}, core_hold, 1);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_error"}, error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        wq_t img;
        wq_t w;
        int  len;
        int  li;
        bus.in_valid = 1'b0;
        bus.in_data  = 9'b0;
        bus.in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;
        @(negedge clk);

        img = '{9'h07E, 9'h066, 9'h07A};
        session(img, 2, 1, 0, 1);

        session(img, 2, 0, 0, 1);
        for (int i = 0; i < 3; i++) check("mem_after_bad", mem_m[i], img[i]);

        session(img, 2, 1, 3, 0);

        w = {};
        for (int i = 0; i < DEPTH; i++) w.push_back(9'($urandom));
        session(w, -1, 1, 0, 1);

        w = {};
        for (int i = 0; i < DEPTH; i++) w.push_back(9'($urandom));
        session(w, DEPTH - 1, 1, 0, 1);

        for (int k = 0; k < 12; k++) begin
            w = {};
            if ($urandom_range(0, 3) == 0) begin
                len = DEPTH + $urandom_range(0, 2);
                li  = -1;
            end else begin
                len = $urandom_range(1, DEPTH);
                li  = len - 1;
            end
            for (int i = 0; i < len; i++) w.push_back(9'($urandom));
            session(w, li, 1'($urandom), $urandom_range(0, 3), 0);
        end

        pulse_start();
        exp_q.push_back('{addr: 0, data: 9'h011});
        send_word(9'h011, 0, 0);
        exp_q.push_back('{addr: 1, data: 9'h022});
        send_word(9'h022, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        w = '{9'h155};
        session(w, 0, 1, 0, 0);
        check("mem_restart", mem_m[0], 9'h155);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
